// File: rtl/s27_bist_pkg.sv
// Shared types and constants for the s27 BIST controller and its LFSR.
package s27_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_RUN,
        ST_DONE
    } state_t;

    // Tap masks select q[7], q[5], q[4], q[3] as the feedback bits.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;
    localparam logic [7:0] MISR_TAPS = 8'hB8;
    localparam logic [7:0] LFSR_SEED = 8'h01;

    // {G3,G2,G1,G0} that drives the s27 flops to G5=1, G6=0, G7=1.
    localparam logic [3:0]  FLUSH_VEC    = 4'b1011;
    localparam int unsigned FLUSH_CYCLES = 2;
    localparam int unsigned FC_W         = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

    // One left shift with XOR feedback of the tapped bits and an optional data input.
    function automatic logic [7:0] shift_fb(input logic [7:0] q,
                                            input logic [7:0] taps,
                                            input logic       din);
        return {q[6:0], (^(q & taps)) ^ din};
    endfunction

endpackage

// File: rtl/s27_bist_lfsr8.sv
// 8-bit Fibonacci LFSR pattern source with synchronous seed load and advance.
module bist_lfsr8
    import s27_bist_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic       i_adv,
    output logic [7:0] o_state,
    output logic [3:0] o_next_low
);

    logic [7:0] r_q;
    logic [7:0] w_next;

    // Next value: load has priority over advance; otherwise hold.
    always_comb begin
        w_next = r_q;
        if (i_load) begin
            w_next = LFSR_SEED;
        end else if (i_adv) begin
            w_next = shift_fb(r_q, LFSR_TAPS, 1'b0);
        end
    end

    // LFSR register, reset to the seed.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= LFSR_SEED;
        end else begin
            r_q <= w_next;
        end
    end

    assign o_state    = r_q;
    assign o_next_low = w_next[3:0];

endmodule

// File: rtl/s27_bist.sv
// BIST controller for the ISCAS s27 circuit: flush, LFSR stimulus, MISR compaction, signature check.
module s27_bist
    import s27_bist_pkg::*;
#(
    parameter int unsigned PAT_COUNT = 255,
    parameter logic [7:0]  GOLDEN    = 8'h00
) (
    input  logic       CK,
    input  logic       RST,
    input  logic       START,
    output logic       G0,
    output logic       G1,
    output logic       G2,
    output logic       G3,
    input  logic       G17,
    output logic       BUSY,
    output logic       DONE,
    output logic [7:0] SIGNATURE,
    output logic       PASS
);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [FC_W-1:0]   r_flush_cnt;
    logic [15:0]       r_pat_cnt;
    logic [7:0]        r_misr;
    logic [3:0]        r_g;
    logic [3:0]        w_g_nxt;

    logic              w_start_ok;
    logic              w_flush_last;
    logic              w_run_last;
    logic              w_lfsr_load;
    logic              w_lfsr_adv;
    logic              w_lfsr_zero;
    logic [7:0]        w_lfsr_q;
    logic [3:0]        w_lfsr_nxt_low;

    assign w_start_ok   = START && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_flush_last = (r_flush_cnt == FC_W'(FLUSH_CYCLES - 1));
    assign w_run_last   = (r_pat_cnt == 16'(PAT_COUNT - 1));

    // An all-zero LFSR would lock up; reseed it rather than emit a constant pattern.
    assign w_lfsr_zero  = (w_lfsr_q == '0);
    assign w_lfsr_load  = w_start_ok || w_lfsr_zero;
    assign w_lfsr_adv   = (r_state == ST_RUN);

    bist_lfsr8 u_lfsr (
        .i_clk      (CK),
        .i_rst      (RST),
        .i_load     (w_lfsr_load),
        .i_adv      (w_lfsr_adv),
        .o_state    (w_lfsr_q),
        .o_next_low (w_lfsr_nxt_low)
    );

    // State register.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: START only honoured from IDLE/DONE, FLUSH and RUN are cycle-counted.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_start_ok)   w_state_nxt = ST_FLUSH;
            ST_FLUSH: if (w_flush_last) w_state_nxt = ST_RUN;
            ST_RUN:   if (w_run_last)   w_state_nxt = ST_DONE;
            ST_DONE:  if (w_start_ok)   w_state_nxt = ST_FLUSH;
            default:                    w_state_nxt = ST_IDLE;
        endcase
    end

    // Output decode; the stimulus for the coming cycle is chosen from the next state
    // so that G can be registered without a cycle of lag.
    always_comb begin
        BUSY    = (r_state == ST_FLUSH) || (r_state == ST_RUN);
        DONE    = (r_state == ST_DONE);
        PASS    = (r_state == ST_DONE) && (r_misr == GOLDEN);
        w_g_nxt = '0;
        case (w_state_nxt)
            ST_FLUSH: w_g_nxt = FLUSH_VEC;
            ST_RUN:   w_g_nxt = w_lfsr_nxt_low;
            default:  w_g_nxt = '0;
        endcase
    end

    // Datapath: stimulus register, flush/pattern counters and MISR compaction in RUN only.
    always_ff @(posedge CK) begin
        if (RST) begin
            r_g         <= '0;
            r_flush_cnt <= '0;
            r_pat_cnt   <= '0;
            r_misr      <= '0;
        end else begin
            r_g <= w_g_nxt;
            if (w_start_ok) begin
                r_flush_cnt <= '0;
                r_pat_cnt   <= '0;
                r_misr      <= '0;
            end else begin
                if (r_state == ST_FLUSH) begin
                    r_flush_cnt <= r_flush_cnt + 1'b1;
                end
                if (r_state == ST_RUN) begin
                    r_pat_cnt <= r_pat_cnt + 16'd1;
                    r_misr    <= shift_fb(r_misr, MISR_TAPS, G17);
                end
            end
        end
    end

    assign G0        = r_g[0];
    assign G1        = r_g[1];
    assign G2        = r_g[2];
    assign G3        = r_g[3];
    assign SIGNATURE = r_misr;

endmodule

// File: tb/tb_s27_bist.sv
// Self-checking bench for s27_bist: directed sequence plus random/s27-driven runs against a timeline model.
module tb_s27_bist;

    logic       CK = 1'b0;
    logic       RST = 1'b1;
    logic       START_A = 1'b0;
    logic       START_B = 1'b0;
    logic       G17_A = 1'b0;
    logic       G17_B;
    logic       g17_drv = 1'b0;
    logic       use_s27 = 1'b0;

    logic       A_G0, A_G1, A_G2, A_G3, A_BUSY, A_DONE, A_PASS;
    logic [7:0] A_SIG;
    logic       B_G0, B_G1, B_G2, B_G3, B_BUSY, B_DONE, B_PASS;
    logic [7:0] B_SIG;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CK = ~CK;

    // Small configuration: two patterns, golden signature 8'h03.
    s27_bist #(.PAT_COUNT(2), .GOLDEN(8'h03)) u_dut_a (
        .CK(CK), .RST(RST), .START(START_A),
        .G0(A_G0), .G1(A_G1), .G2(A_G2), .G3(A_G3),
        .G17(G17_A), .BUSY(A_BUSY), .DONE(A_DONE), .SIGNATURE(A_SIG), .PASS(A_PASS)
    );

    // Default configuration: 255 patterns, golden signature 8'h00.
    s27_bist u_dut_b (
        .CK(CK), .RST(RST), .START(START_B),
        .G0(B_G0), .G1(B_G1), .G2(B_G2), .G3(B_G3),
        .G17(G17_B), .BUSY(B_BUSY), .DONE(B_DONE), .SIGNATURE(B_SIG), .PASS(B_PASS)
    );

    // ISCAS s27 gate netlist; st = {G5,G6,G7}; returns {G17, next G5, next G6, next G7}.
    function automatic logic [3:0] s27_eval(input logic [3:0] g, input logic [2:0] st);
        logic g8, g9, g10, g11, g12, g13, g14, g15, g16;
        g14 = ~g[0];
        g8  = g14 & st[1];
        g12 = ~(g[1] | st[0]);
        g15 = g12 | g8;
        g16 = g[3] | g8;
        g9  = ~(g16 & g15);
        g11 = ~(st[2] | g9);
        g10 = ~(g14 | g11);
        g13 = ~(g[2] | g12);
        return {~g11, g10, g11, g13};
    endfunction

    // Physical s27 instance hooked to DUT B's stimulus.
    logic [2:0] hw_st = 3'b000;
    logic [3:0] hw_ev;
    assign hw_ev = s27_eval({B_G3, B_G2, B_G1, B_G0}, hw_st);
    always @(posedge CK) hw_st <= hw_ev[2:0];
    assign G17_B = use_s27 ? hw_ev[3] : g17_drv;

    function automatic logic [7:0] lfsr_nxt(input logic [7:0] q);
        return {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
    endfunction

    function automatic logic [7:0] misr_nxt(input logic [7:0] m, input logic d);
        return {m[6:0], m[7] ^ m[5] ^ m[4] ^ m[3] ^ d};
    endfunction

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_a(input string tag, input logic [3:0] g, input logic busy,
                         input logic done, input logic [7:0] sig, input logic pass);
        chk({tag, ".a.G"},    {A_G3, A_G2, A_G1, A_G0}, g);
        chk({tag, ".a.BUSY"}, A_BUSY, busy);
        chk({tag, ".a.DONE"}, A_DONE, done);
        chk({tag, ".a.SIG"},  A_SIG,  sig);
        chk({tag, ".a.PASS"}, A_PASS, pass);
    endtask

    task automatic chk_b(input string tag, input logic [3:0] g, input logic busy,
                         input logic done, input logic [7:0] sig, input logic pass);
        chk({tag, ".b.G"},    {B_G3, B_G2, B_G1, B_G0}, g);
        chk({tag, ".b.BUSY"}, B_BUSY, busy);
        chk({tag, ".b.DONE"}, B_DONE, done);
        chk({tag, ".b.SIG"},  B_SIG,  sig);
        chk({tag, ".b.PASS"}, B_PASS, pass);
    endtask

    // One full run on DUT B from IDLE or DONE. mode 0: G17=0, 1: random G17, 2: s27 drives G17.
    // poke: issue extra START pulses during FLUSH and mid-RUN. If stop_at >= 0, abort with RST there.
    task automatic run_b(input int mode, input bit poke, input int stop_at, output logic [7:0] sig);
        logic [7:0] lf, m;
        logic [2:0] rs;
        logic [3:0] ev;
        logic       d;
        lf = 8'h01;
        m  = 8'h00;
        rs = 3'b000;
        use_s27 = (mode == 2);
        START_B = 1'b1;
        tick();
        START_B = 1'b0;
        for (int c = 0; c < 2; c++) begin
            chk_b("flush", 4'b1011, 1'b1, 1'b0, 8'h00, 1'b0);
            START_B = poke && (c == 0);
            g17_drv = 1'($urandom_range(0, 1));
            ev = s27_eval(4'b1011, rs);
            rs = ev[2:0];
            tick();
            START_B = 1'b0;
        end
        for (int k = 0; k < 255; k++) begin
            if (k == stop_at) begin
                RST = 1'b1;
                tick();
                RST = 1'b0;
                chk_b("rst_mid_run", 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
                tick();
                chk_b("idle_after_rst", 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
                sig = 8'h00;
                return;
            end
            chk_b("run", lf[3:0], 1'b1, 1'b0, m, 1'b0);
            ev = s27_eval(lf[3:0], rs);
            case (mode)
                0:       d = 1'b0;
                1:       d = 1'($urandom_range(0, 1));
                default: d = ev[3];
            endcase
            g17_drv = d;
            START_B = poke && (k == 100);
            m  = misr_nxt(m, d);
            lf = lfsr_nxt(lf);
            rs = ev[2:0];
            tick();
            START_B = 1'b0;
        end
        chk_b("done", 4'b0000, 1'b0, 1'b1, m, (m == 8'h00));
        for (int h = 0; h < 3; h++) begin
            g17_drv = 1'($urandom_range(0, 1));
            tick();
            chk_b("done_hold", 4'b0000, 1'b0, 1'b1, m, (m == 8'h00));
        end
        sig = m;
    endtask

    logic [7:0] sig_1, sig_2, sig_tmp;

    initial begin
        // Reset
        RST = 1'b1;
        tick();
        RST = 1'b0;
        chk_a("reset", 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);
        chk_b("reset", 4'b0000, 1'b0, 1'b0, 8'h00, 1'b0);

        // Two-pattern run with G17 tied high: 8'h01 then 8'h03, PASS against GOLDEN 8'h03
        G17_A   = 1'b1;
        START_A = 1'b1;
        tick();
        START_A = 1'b0;
        chk_a("a_flush0", 4'b1011, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        chk_a("a_flush1", 4'b1011, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        chk_a("a_run0",   4'b0001, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        chk_a("a_run1",   4'b0010, 1'b1, 1'b0, 8'h01, 1'b0);
        tick();
        chk_a("a_done",   4'b0000, 1'b0, 1'b1, 8'h03, 1'b1);
        tick();
        chk_a("a_hold",   4'b0000, 1'b0, 1'b1, 8'h03, 1'b1);

        // Restart from DONE with G17 low: DONE/PASS drop, signature clears, final 8'h00 fails GOLDEN
        G17_A   = 1'b0;
        START_A = 1'b1;
        tick();
        START_A = 1'b0;
        chk_a("a_restart", 4'b1011, 1'b1, 1'b0, 8'h00, 1'b0);
        repeat (3) tick();
        chk_a("a_run1_b",  4'b0010, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        chk_a("a_done_b",  4'b0000, 1'b0, 1'b1, 8'h00, 1'b0);

        // Default run with G17 tied low: DONE after 2+255 cycles, signature 8'h00, PASS
        run_b(0, 1'b0, -1, sig_tmp);
        // Random response with ignored START pulses in FLUSH and RUN
        run_b(1, 1'b1, -1, sig_tmp);
        // Reset in the middle of RUN
        run_b(1, 1'b0, 50, sig_tmp);
        // Random run straight out of IDLE after the abort
        run_b(1, 1'b0, -1, sig_tmp);
        // s27 in the loop, two back-to-back runs restarting from DONE
        run_b(2, 1'b0, -1, sig_1);
        run_b(2, 1'b1, -1, sig_2);
        chk("s27_repeat_sig", B_SIG, sig_1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/s27_bist.md
S27_BIST -- requirements
Module: s27_bist

Interface
REQ-001 Parameter PAT_COUNT, default 255, number of pseudo-random patterns applied in RUN; legal range 1..65535.
REQ-002 Parameter GOLDEN, default 8'h00, expected 8-bit MISR signature for PASS.
REQ-003 CK  input  1  single clock; all state updates on rising edge.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 START  input  1  one-cycle start request; honoured only in IDLE or DONE.
REQ-006 G0, G1, G2, G3  output  1 each  registered stimulus driven into s27 inputs of the same names.
REQ-007 G17  input  1  s27 response, sampled on CK.
REQ-008 BUSY  output  1  high in FLUSH and RUN.
REQ-009 DONE  output  1  high in DONE state.
REQ-010 SIGNATURE  output  8  current MISR contents.
REQ-011 PASS  output  1  high only in DONE when SIGNATURE == GOLDEN.

Function
REQ-012 FSM states IDLE, FLUSH, RUN, DONE shall be used; transitions IDLE/DONE -START-> FLUSH, FLUSH -2 cycles-> RUN, RUN -PAT_COUNT cycles-> DONE.
REQ-013 START in FLUSH or RUN shall be ignored.
REQ-014 In IDLE and DONE, {G3,G2,G1,G0} shall be 4'b0000.
REQ-015 In both FLUSH cycles, {G3,G2,G1,G0} shall be 4'b1011; this forces s27 state to G5=1, G6=0, G7=1 regardless of prior state.
REQ-016 Pattern source: 8-bit Fibonacci LFSR, shift left, feedback q[7]^q[5]^q[4]^q[3] into q[0], seed 8'h01.
REQ-017 In RUN cycle k (k=0..PAT_COUNT-1), {G3,G2,G1,G0} shall equal LFSR low nibble after k advances from seed; the LFSR advances once per RUN cycle.
REQ-018 MISR: 8-bit, m <= {m[6:0], m[7]^m[5]^m[4]^m[3]^G17}, updated on the rising edge ending every RUN cycle only; G17 is never compacted in FLUSH, IDLE or DONE.
REQ-019 Pattern counter: 16 bits, cleared on START; RUN exits on the edge where exactly PAT_COUNT patterns have been compacted.
REQ-020 On START acceptance (IDLE or DONE), LFSR shall reload 8'h01, MISR shall clear to 8'h00, DONE and PASS shall drop in the next cycle.
REQ-021 DONE, SIGNATURE and PASS shall hold stable in DONE until START or RST.
REQ-022 BUSY shall rise the cycle after START is accepted and fall the cycle DONE rises.

Reset
REQ-023 RST sampled high shall, on that edge, force state IDLE, LFSR 8'h01, MISR 8'h00, counter 0, G0..G3 0, BUSY 0, DONE 0, PASS 0.
REQ-024 RST shall take priority over START and over any in-progress FLUSH/RUN.

Structure
REQ-025 Package s27_bist_pkg shall hold the state enum, LFSR taps, MISR taps, LFSR seed, FLUSH_VEC (4'b1011) and FLUSH_CYCLES (2).
REQ-026 The LFSR shall be a sub-module bist_lfsr8 (load, advance, 8-bit state out); FSM, counter and MISR live in s27_bist.

Verification
REQ-027 Reset: assert RST 1 cycle -> next cycle all outputs 0, SIGNATURE 8'h00, state IDLE.
REQ-028 START pulse from IDLE -> BUSY=1 next cycle; G outputs 4'b1011 for exactly 2 cycles; then first RUN cycle 4'b0001, second 4'b0010.
REQ-029 PAT_COUNT=2, G17 tied 1 -> SIGNATURE 8'h01 then 8'h03; DONE=1 with SIGNATURE 8'h03; PASS=1 iff GOLDEN=8'h03.
REQ-030 G17 tied 0, default PAT_COUNT -> DONE after 2+255 cycles, SIGNATURE 8'h00, PASS=1 with GOLDEN=8'h00.
REQ-031 START pulses during FLUSH and mid-RUN -> no effect on cycle count or signature; RST mid-RUN -> IDLE next cycle, all outputs at reset values.
REQ-032 Connected to s27 model, two back-to-back runs (restart from DONE) -> identical SIGNATURE both times.
